// File: rtl/int_stim_gen_pkg.sv
// Shared definitions for the interrupt stimulus generator.
//   - chan_state_t     : per-channel FSM encoding
//   - ACK_BASE_DEFAULT : word address of channel 0 acknowledge
//   - WORD_MASK        : clears byte-offset bits of a 32-bit address
package int_stim_gen_pkg;

  localparam logic [31:0] ACK_BASE_DEFAULT = 32'h0000_7f20;
  localparam logic [31:0] WORD_MASK        = ~32'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ASSERT = 2'd2
  } chan_state_t;

endpackage

// File: rtl/int_stim_chan.sv
// Single interrupt channel: PC match, optional delay, held request, fire count.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   enable          : global arm for new matches
//   pc, target      : macroscopic PC and this channel's target (bits [1:0] ignored)
//   limit, dly      : fire limit (0 disables) and match-to-assert delay
//   ack             : decoded acknowledge store for this channel
//   irq             : registered request
//   fired           : completed-fire count, saturating
module int_stim_chan
  import int_stim_gen_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      pc,
  input  logic [31:0]      target,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] dly,
  input  logic             ack,
  output logic             irq,
  output logic [CNT_W-1:0] fired
);

  chan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] fired_next;
  logic             irq_next;
  logic             match_c;

  // Match qualifies on enable, a non-zero limit not yet reached and a word-aligned PC hit.
  assign match_c = enable && (limit != '0) && (fired < limit) &&
                   ((pc & WORD_MASK) == (target & WORD_MASK));

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      fired <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      fired <= fired_next;
      irq   <= irq_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (match_c) state_next = (dly == '0) ? ST_ASSERT : ST_DELAY;
      end
      ST_DELAY: begin
        if (cnt == '0) state_next = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter, fire count and request; irq follows the next state so it rises on the entering edge.
  always_comb begin
    cnt_next   = cnt;
    fired_next = fired;
    irq_next   = (state_next == ST_ASSERT);
    unique case (state)
      ST_IDLE: begin
        // Loading delay-1 makes the request rise exactly delay edges after the match edge.
        if (match_c && (dly != '0)) cnt_next = dly - CNT_W'(1);
      end
      ST_DELAY: begin
        if (cnt != '0) cnt_next = cnt - CNT_W'(1);
      end
      ST_ASSERT: begin
        if (ack && (fired != '1)) fired_next = fired + CNT_W'(1);
      end
      default: cnt_next = '0;
    endcase
  end

endmodule

// File: rtl/int_stim_gen.sv
// Multi-channel interrupt stimulus generator for CPU-level verification.
// Raises `interrupt` when the macroscopic PC hits a programmed target, holds
// the request until the handler stores to the channel's acknowledge word.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : global arm for new matches
//   macroscopic_pc : CPU PC (bits [1:0] ignored)
//   target_pc      : 32 bits per channel
//   fire_limit     : CNT_W bits per channel, 0 disables
//   delay          : CNT_W bits per channel, match-to-assert cycles
//   m_int_addr     : CPU interrupt-device store address
//   m_int_byteen   : store byte enables, any bit set marks a store
//   irq_vec        : per-channel registered request
//   interrupt      : OR of irq_vec
//   fired          : CNT_W bits per channel, completed fires
module int_stim_gen
  import int_stim_gen_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter logic [31:0] ACK_BASE = ACK_BASE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [31:0]               macroscopic_pc,
  input  logic [32*CHANNELS-1:0]    target_pc,
  input  logic [CNT_W*CHANNELS-1:0] fire_limit,
  input  logic [CNT_W*CHANNELS-1:0] delay,
  input  logic [31:0]               m_int_addr,
  input  logic [3:0]                m_int_byteen,
  output logic [CHANNELS-1:0]       irq_vec,
  output logic                      interrupt,
  output logic [CNT_W*CHANNELS-1:0] fired
);

  logic        store_c;
  logic [31:0] store_word_c;

  assign store_c      = |m_int_byteen;
  assign store_word_c = m_int_addr & WORD_MASK;

  // One channel per source; each decodes its own acknowledge word.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam logic [31:0] ACK_ADDR = ACK_BASE + 32'(4 * i);

    logic ack_c;
    assign ack_c = store_c && (store_word_c == ACK_ADDR);

    int_stim_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .pc     (macroscopic_pc),
      .target (target_pc[32*i +: 32]),
      .limit  (fire_limit[CNT_W*i +: CNT_W]),
      .dly    (delay[CNT_W*i +: CNT_W]),
      .ack    (ack_c),
      .irq    (irq_vec[i]),
      .fired  (fired[CNT_W*i +: CNT_W])
    );
  end

  // Combinational OR of registered bits; reset clears it without waiting for an edge.
  assign interrupt = |irq_vec;

endmodule

// File: tb/tb_int_stim_gen.sv
// Self-checking bench for int_stim_gen: directed vector tables, hand-written
// multi-cycle sequences and a randomized run against a time-based reference model.
module tb_int_stim_gen;

  localparam int          NCH = 4;
  localparam int          CW  = 8;
  localparam logic [31:0] ACK = 32'h0000_7f20;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [31:0]       macroscopic_pc;
  logic [32*NCH-1:0] target_pc;
  logic [CW*NCH-1:0] fire_limit;
  logic [CW*NCH-1:0] delay;
  logic [31:0]       m_int_addr;
  logic [3:0]        m_int_byteen;
  logic [NCH-1:0]    irq_vec;
  logic              interrupt;
  logic [CW*NCH-1:0] fired;

  int_stim_gen #(
    .CHANNELS (NCH),
    .CNT_W    (CW),
    .ACK_BASE (ACK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .macroscopic_pc (macroscopic_pc),
    .target_pc      (target_pc),
    .fire_limit     (fire_limit),
    .delay          (delay),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .irq_vec        (irq_vec),
    .interrupt      (interrupt),
    .fired          (fired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [3:0]  exp_irq;
    logic [7:0]  exp_fired0;
  } vec_t;

  vec_t tbl_a [6];
  vec_t tbl_b [5];

  int n_vec;
  int n_err;

  // Reference model: a fire is "active" from its match edge until acked; it is
  // visible on irq from edge (match_edge + delay) on.
  int          cfg_tgt   [NCH];
  int          cfg_lim   [NCH];
  int          cfg_dly   [NCH];
  bit          m_active  [NCH];
  int          m_rise    [NCH];
  int          m_fired   [NCH];
  int          edge_n;
  logic [NCH-1:0]    exp_irq;
  logic [CW*NCH-1:0] exp_fired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic set_chan(input int i, input logic [31:0] t, input int l, input int d);
    cfg_tgt[i] = int'(t);
    cfg_lim[i] = l;
    cfg_dly[i] = d;
    target_pc[32*i +: 32]  = t;
    fire_limit[CW*i +: CW] = 8'(l);
    delay[CW*i +: CW]      = 8'(d);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_active[i] = 1'b0;
      m_rise[i]   = 0;
      m_fired[i]  = 0;
    end
  endtask

  task automatic model_step(input logic [31:0] p, input logic e, input logic [31:0] a,
                            input logic [3:0] b);
    edge_n++;
    for (int i = 0; i < NCH; i++) begin
      bit ack_i;
      bit match_i;
      ack_i   = (b != 4'd0) && ((a & ~32'd3) == ACK + 32'(4 * i));
      match_i = e && (cfg_lim[i] != 0) && (m_fired[i] < cfg_lim[i]) &&
                ((p & ~32'd3) == (32'(cfg_tgt[i]) & ~32'd3));
      if (m_active[i]) begin
        // Ack only lands once the request was visible before this edge.
        if (ack_i && edge_n > m_rise[i]) begin
          m_active[i] = 1'b0;
          if (m_fired[i] < 255) m_fired[i]++;
        end
      end else if (match_i) begin
        m_active[i] = 1'b1;
        m_rise[i]   = edge_n + cfg_dly[i];
      end
      exp_irq[i] = m_active[i] && (edge_n >= m_rise[i]);
      exp_fired[CW*i +: CW] = 8'(m_fired[i]);
    end
  endtask

  task automatic tick(input logic [31:0] p, input logic e, input logic [31:0] a,
                      input logic [3:0] b);
    macroscopic_pc = p;
    enable         = e;
    m_int_addr     = a;
    m_int_byteen   = b;
    model_step(p, e, a, b);
    @(posedge clk);
    #1;
    check("model_irq_vec", 32'(irq_vec), 32'(exp_irq));
    check("model_interrupt", 32'(interrupt), 32'(|exp_irq));
    check("model_fired", fired, exp_fired);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    check("rst_fired", fired, 32'd0);
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  task automatic only_chan0(input logic [31:0] t, input int l, input int d);
    set_chan(0, t, l, d);
    for (int i = 1; i < NCH; i++) set_chan(i, 32'h0000_3018, 0, 0);
  endtask

  initial begin
    int asserts;

    n_vec  = 0;
    n_err  = 0;
    edge_n = 0;
    exp_irq   = '0;
    exp_fired = '0;
    model_clear();

    // Single channel, target 0x3018, limit 1, delay 0.
    tbl_a[0] = '{32'h3000, 1'b1, 32'h0,    4'h0, 4'b0000, 8'd0};
    tbl_a[1] = '{32'h3018, 1'b1, 32'h0,    4'h0, 4'b0001, 8'd0};
    tbl_a[2] = '{32'h301c, 1'b1, 32'h0,    4'h0, 4'b0001, 8'd0};
    tbl_a[3] = '{32'h3020, 1'b1, 32'h7f20, 4'hf, 4'b0000, 8'd1};
    tbl_a[4] = '{32'h3018, 1'b1, 32'h0,    4'h0, 4'b0000, 8'd1};
    tbl_a[5] = '{32'h301a, 1'b1, 32'h0,    4'h0, 4'b0000, 8'd1};
    // Two channels, targets 0x3018 / 0x301c; ack channel 1 first.
    tbl_b[0] = '{32'h3018, 1'b1, 32'h0,    4'h0, 4'b0001, 8'd0};
    tbl_b[1] = '{32'h301c, 1'b1, 32'h0,    4'h0, 4'b0011, 8'd0};
    tbl_b[2] = '{32'h3020, 1'b1, 32'h7f24, 4'h1, 4'b0001, 8'd0};
    tbl_b[3] = '{32'h3024, 1'b1, 32'h0,    4'h0, 4'b0001, 8'd0};
    tbl_b[4] = '{32'h3028, 1'b1, 32'h7f22, 4'h2, 4'b0000, 8'd1};

    reset          = 1'b1;
    enable         = 1'b0;
    macroscopic_pc = '0;
    m_int_addr     = '0;
    m_int_byteen   = '0;
    target_pc      = '0;
    fire_limit     = '0;
    delay          = '0;
    only_chan0(32'h3018, 1, 0);
    #12;
    check("reset_irq_vec", 32'(irq_vec), 32'd0);
    check("reset_interrupt", 32'(interrupt), 32'd0);
    check("reset_fired", fired, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      tick(tbl_a[k].pc, tbl_a[k].en, tbl_a[k].addr, tbl_a[k].be);
      check("tblA_irq_vec", 32'(irq_vec), 32'(tbl_a[k].exp_irq));
      check("tblA_fired0", 32'(fired[7:0]), 32'(tbl_a[k].exp_fired0));
    end

    do_reset();
    only_chan0(32'h3018, 1, 0);
    set_chan(1, 32'h301c, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick(tbl_b[k].pc, tbl_b[k].en, tbl_b[k].addr, tbl_b[k].be);
      check("tblB_irq_vec", 32'(irq_vec), 32'(tbl_b[k].exp_irq));
      check("tblB_interrupt", 32'(interrupt), 32'(tbl_b[k].exp_irq != 4'd0));
      check("tblB_fired0", 32'(fired[7:0]), 32'(tbl_b[k].exp_fired0));
    end

    // Delay 3: rises on the 4th edge after the match cycle; early ack ignored.
    do_reset();
    only_chan0(32'h3020, 1, 3);
    tick(32'h3020, 1'b1, 32'h0, 4'h0);
    check("dly_e0", 32'(irq_vec[0]), 32'd0);
    tick(32'h3024, 1'b1, 32'h7f20, 4'hf);
    check("dly_e1_ack_ignored", 32'(irq_vec[0]), 32'd0);
    tick(32'h3028, 1'b1, 32'h0, 4'h0);
    check("dly_e2", 32'(irq_vec[0]), 32'd0);
    tick(32'h302c, 1'b1, 32'h0, 4'h0);
    check("dly_e3_rise", 32'(irq_vec[0]), 32'd1);
    tick(32'h3030, 1'b1, 32'h7f20, 4'hf);
    check("dly_acked", 32'(irq_vec[0]), 32'd0);
    check("dly_fired", 32'(fired[7:0]), 32'd1);

    // Limit 2: exactly two assertions across three visits.
    do_reset();
    only_chan0(32'h3018, 2, 0);
    asserts = 0;
    for (int k = 0; k < 3; k++) begin
      tick(32'h3018, 1'b1, 32'h0, 4'h0);
      if (irq_vec[0]) asserts++;
      tick(32'h3000, 1'b1, 32'h7f20, 4'hf);
    end
    check("limit2_asserts", 32'(asserts), 32'd2);
    check("limit2_fired", 32'(fired[7:0]), 32'd2);

    // Disabled arm and zero limit both suppress matches.
    do_reset();
    only_chan0(32'h3018, 1, 0);
    tick(32'h3018, 1'b0, 32'h0, 4'h0);
    check("enable0_no_irq", 32'(interrupt), 32'd0);
    set_chan(0, 32'h3018, 0, 0);
    tick(32'h3018, 1'b1, 32'h0, 4'h0);
    check("limit0_no_irq", 32'(interrupt), 32'd0);

    // Reset while asserted clears the count and the channel re-fires.
    only_chan0(32'h3018, 2, 0);
    tick(32'h3018, 1'b1, 32'h0, 4'h0);
    tick(32'h3000, 1'b1, 32'h7f20, 4'h8);
    tick(32'h3018, 1'b1, 32'h0, 4'h0);
    check("pre_rst_assert", 32'(interrupt), 32'd1);
    check("pre_rst_fired", 32'(fired[7:0]), 32'd1);
    do_reset();
    tick(32'h3018, 1'b1, 32'h0, 4'h0);
    check("post_rst_refire", 32'(irq_vec[0]), 32'd1);

    // Randomized run against the reference model.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] p;
      logic [31:0] a;
      logic [3:0]  b;
      logic        e;
      if (k % 60 == 0) begin
        for (int i = 0; i < NCH; i++)
          set_chan(i, 32'h3000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      end
      p = 32'h3000 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) begin
        a = ACK + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
        b = 4'($urandom_range(0, 15));
      end else begin
        a = 32'h0;
        b = 4'h0;
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      tick(p, e, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_stim_gen.md
# int_stim_gen

Parametrised, synthesizable interrupt stimulus generator for CPU-level verification of the pipelined MIPS core. It watches `macroscopic_pc` and raises the external `interrupt` line when the PC hits any of `CHANNELS` programmable targets, optionally after a per-channel delay and up to a per-channel fire limit. It holds each request until the handler acknowledges it with a store to that channel's acknowledge word. It sits beside `mips` in the system testbench and replaces single-target, single-shot interrupt injection.

## Interface
- `CHANNELS`, 4: number of independent interrupt sources (1..8).
- `CNT_W`, 8: width of fire-limit and delay fields.
- `ACK_BASE`, 32'h0000_7f20: word address of channel 0 acknowledge; channel i acknowledges at `ACK_BASE + 4*i`.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `enable` input 1: global arm; when low, no new matches are accepted, and pending or asserted requests continue.
- `macroscopic_pc` input 32: CPU macroscopic PC; bits [1:0] ignored.
- `target_pc` input 32*CHANNELS: channel i target in bits [32i+31:32i].
- `fire_limit` input CNT_W*CHANNELS: maximum fires per channel; 0 disables the channel.
- `delay` input CNT_W*CHANNELS: cycles between match and assertion; 0 asserts on the next edge.
- `m_int_addr` input 32: CPU interrupt-device store address.
- `m_int_byteen` input 4: store byte enables; any bit set marks a store.
- `irq_vec` output CHANNELS: per-channel request, registered.
- `interrupt` output 1: OR of `irq_vec`, connected to the CPU `interrupt` input.
- `fired` output CNT_W*CHANNELS: per-channel completed-fire count.

## Operation
- Per-channel FSM with states IDLE, DELAY, ASSERT. Reset places all channels in IDLE, clears `irq_vec`, `interrupt`, `fired` and delay counters to 0.
- Match(i) = `enable` & `fire_limit[i]` != 0 & `fired[i]` < `fire_limit[i]` & (`macroscopic_pc` & ~3) == (`target_pc[i]` & ~3).
- Ack(i) = |`m_int_byteen` & (`m_int_addr` & ~3) == `ACK_BASE` + 4*i.
- IDLE to DELAY on Match(i) with delay != 0; the counter loads `delay[i]` − 1.
- IDLE to ASSERT on Match(i) with delay == 0.
- DELAY decrements its counter each cycle and moves to ASSERT when the counter is 0.
- ASSERT drives `irq_vec[i]` = 1. On Ack(i) it goes to IDLE, and `fired[i]` increments, saturating at all-ones.
- An Ack(i) in IDLE or DELAY is ignored and does not cancel the pending fire.
- Matches while in DELAY or ASSERT are ignored; there is no queuing.
- After returning to IDLE, the same PC re-arms only on a new Match. A PC held at the target re-fires the next cycle if the limit permits. This is intended: the handler return revisits the target.
- Channels are fully independent. Several may be in ASSERT at once, and `interrupt` stays high until all are acked.
- `fire_limit`, `delay` and `target_pc` are sampled only on IDLE transitions. Changes mid-DELAY do not affect the running count.

## Timing
- `irq_vec[i]` rises one edge after the matching PC cycle when delay = 0, and 1 + `delay[i]` edges after it otherwise.
- `irq_vec[i]` falls on the edge that samples Ack(i). `fired[i]` updates on the same edge.
- `interrupt` is combinational OR of registered bits, so it adds no extra latency.
- Reset asserted mid-DELAY or mid-ASSERT drops `interrupt` immediately (asynchronously) and discards progress and counts.

## Structure
- A shared package holds the state encoding (IDLE=2'd0, DELAY=2'd1, ASSERT=2'd2) and the default `ACK_BASE` constant.
- One sub-module, `int_stim_chan`, holds the single-channel FSM, delay counter and fire counter. The top level instantiates it with a generate loop and builds the OR.

## Test plan
- CHANNELS=1, target 0x3018, limit 1, delay 0. PC reaches 0x3018, so `interrupt` rises the next edge. A store to 0x7f20 with byteen 4'b1111 drops it, and `fired`=1. A second visit to 0x3018 produces no interrupt.
- Delay 3, target 0x3020: `irq_vec[0]` rises exactly 4 edges after the match cycle. A store to 0x7f20 during DELAY is ignored, and the request still asserts.
- Limit 2, PC revisits 0x3018 after each ack: exactly two assertions, then `fired`=2 and no further requests.
- Two channels, targets 0x3018 and 0x301c, both delay 0, PC steps 0x3018 then 0x301c: both bits set. A store to 0x7f24 clears only bit 1, and `interrupt` stays high until a store to 0x7f20.
- `enable`=0 while PC=0x3018: no request. Matches with `fire_limit`=0 are also ignored.
- Reset pulse while in ASSERT: `interrupt` goes to 0 before the next clock edge, `fired`=0, and the channel re-fires on the next match.
